// File: rtl/huffman_sched.sv
// Round-robin frame scheduler feeding the 6-symbol huffman core: clear, stream, wait, report.
// Optional statistics counters are built when HUFF_SCHED_STAT_EN is defined.
module huffman_sched #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_i,
  input  logic [LEN_W-1:0] len0_i,
  input  logic [LEN_W-1:0] len1_i,
  input  logic [7:0]       data0_i,
  input  logic [7:0]       data1_i,
  output logic [1:0]       rd_o,
  output logic [1:0]       grant_o,
  output logic [1:0]       done_o,
  output logic             core_rst_o,
  output logic             gray_valid,
  output logic [7:0]       gray_data,
  input  logic             code_valid,
  output logic             res_valid,
  output logic             res_id,
  output logic [1:0]       res_err,
  input  logic             res_ack_i,
  output logic [2:0]       fsm_state
`ifdef HUFF_SCHED_STAT_EN
  ,
  output logic [15:0]      frames0_o,
  output logic [15:0]      frames1_o,
  output logic [15:0]      err_cnt_o
`endif
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t           state;
  logic             ptr;
  logic [LEN_W-1:0] cnt;
  logic [TW-1:0]    timer;

  logic             pick;
  logic [LEN_W-1:0] pick_len;
  logic [7:0]       sym_raw;
  logic [7:0]       sym_clamped;
  logic             sym_bad;

  assign fsm_state = state;

  // Tie between both requesters goes to ptr; a lone requester always wins.
  always_comb begin
    pick     = (req_i == 2'b11) ? ptr : req_i[1];
    pick_len = pick ? len1_i : len0_i;
  end

  always_comb begin
    sym_raw     = grant_o[1] ? data1_i : data0_i;
    sym_bad     = (sym_raw == 8'd0) || (sym_raw > 8'd6);
    sym_clamped = sym_raw;
    if (sym_raw == 8'd0)
      sym_clamped = 8'd1;
    else if (sym_raw > 8'd6)
      sym_clamped = 8'd6;
  end

  assign gray_data = gray_valid ? sym_clamped : 8'd0;

  // Result handshake: res_valid, res_id and res_err stay stable from rise until the
  // cycle res_ack_i is seen high; that edge retires the result and pulses done_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      timer      <= '0;
      rd_o       <= 2'b00;
      grant_o    <= 2'b00;
      done_o     <= 2'b00;
      core_rst_o <= 1'b0;
      gray_valid <= 1'b0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_err    <= 2'b00;
    end else begin
      done_o <= 2'b00;
      case (state)
        S_IDLE: begin
          // The done_o cycle is skipped so a requester can drop its level request.
          if (req_i != 2'b00 && done_o == 2'b00) begin
            grant_o <= pick ? 2'b10 : 2'b01;
            res_id  <= pick;
            ptr     <= ~pick;
            cnt     <= pick_len;
            if (pick_len == '0) begin
              res_err   <= 2'b10;
              res_valid <= 1'b1;
              state     <= S_RESULT;
            end else begin
              res_err    <= 2'b00;
              core_rst_o <= 1'b1;
              state      <= S_CLR;
            end
          end
        end
        S_CLR: begin
          core_rst_o <= 1'b0;
          rd_o       <= grant_o;
          gray_valid <= 1'b1;
          state      <= S_STREAM;
        end
        S_STREAM: begin
          if (sym_bad)
            res_err[0] <= 1'b1;
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            rd_o       <= 2'b00;
            gray_valid <= 1'b0;
            timer      <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The clear pulse is raised one cycle early so it lands on timer==TIMEOUT.
          if (timer == TW'(TIMEOUT)) begin
            core_rst_o <= 1'b0;
            res_err[1] <= 1'b1;
            res_valid  <= 1'b1;
            state      <= S_RESULT;
          end else if (code_valid) begin
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else begin
            timer <= timer + TW'(1);
            if (timer == TW'(TIMEOUT - 1))
              core_rst_o <= 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ack_i) begin
            res_valid <= 1'b0;
            res_err   <= 2'b00;
            res_id    <= 1'b0;
            done_o    <= grant_o;
            grant_o   <= 2'b00;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HUFF_SCHED_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames0_o <= 16'd0;
      frames1_o <= 16'd0;
      err_cnt_o <= 16'd0;
    end else if (state == S_RESULT && res_ack_i) begin
      if (grant_o[0] && frames0_o != 16'hFFFF)
        frames0_o <= frames0_o + 16'd1;
      if (grant_o[1] && frames1_o != 16'hFFFF)
        frames1_o <= frames1_o + 16'd1;
      if (res_err != 2'b00 && err_cnt_o != 16'hFFFF)
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_sched.sv
// Bench for huffman_sched: behavioural core model, random frames, fixed scenario tasks.
module tb_huffman_sched;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       req_i;
  logic [LEN_W-1:0] len0_i, len1_i;
  logic [7:0]       data0_i, data1_i;
  logic [1:0]       rd_o, grant_o, done_o;
  logic             core_rst_o, gray_valid;
  logic [7:0]       gray_data;
  logic             code_valid;
  logic             res_valid, res_id;
  logic [1:0]       res_err;
  logic             res_ack_i;
  logic [2:0]       fsm_state;
`ifdef HUFF_SCHED_STAT_EN
  logic [15:0]      frames0_o, frames1_o, err_cnt_o;
`endif

  huffman_sched #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .len0_i(len0_i), .len1_i(len1_i),
    .data0_i(data0_i), .data1_i(data1_i), .rd_o(rd_o), .grant_o(grant_o), .done_o(done_o),
    .core_rst_o(core_rst_o), .gray_valid(gray_valid), .gray_data(gray_data),
    .code_valid(code_valid), .res_valid(res_valid), .res_id(res_id), .res_err(res_err),
    .res_ack_i(res_ack_i), .fsm_state(fsm_state)
`ifdef HUFF_SCHED_STAT_EN
    , .frames0_o(frames0_o), .frames1_o(frames1_o), .err_cnt_o(err_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- requester sources ----------------
  logic [7:0] src0_mem [0:255];
  logic [7:0] src1_mem [0:255];
  int idx0 = 0;
  int idx1 = 0;

  assign data0_i = src0_mem[8'(idx0)];
  assign data1_i = src1_mem[8'(idx1)];

  always @(posedge clk) begin
    if (rd_o[0]) idx0 <= idx0 + 1;
    if (rd_o[1]) idx1 <= idx1 + 1;
  end

  // ---------------- core model ----------------
  bit core_hang;
  int core_delay;
  logic prev_gv;
  int cv_timer;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_gv    <= 1'b0;
      cv_timer   <= 0;
      code_valid <= 1'b0;
    end else begin
      prev_gv    <= gray_valid;
      code_valid <= 1'b0;
      if (core_rst_o)
        cv_timer <= 0;
      else if (prev_gv && !gray_valid && !core_hang)
        cv_timer <= core_delay;
      else if (cv_timer == 1) begin
        code_valid <= 1'b1;
        cv_timer   <= 0;
      end else if (cv_timer != 0)
        cv_timer <= cv_timer - 1;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int model_pref;
  logic [7:0] exp_q[$];
  bit exp_bad;

  function automatic logic [7:0] model_clamp(input logic [7:0] s);
    if (s < 8'd1) return 8'd1;
    if (s > 8'd6) return 8'd6;
    return s;
  endfunction

  function automatic int model_pick(input logic [1:0] req, input int pref);
    if (req == 2'b11) return pref;
    return req[1] ? 1 : 0;
  endfunction

  task automatic model_frame(input int r, input int len);
    logic [7:0] s;
    exp_q.delete();
    exp_bad = 1'b0;
    for (int k = 0; k < len; k++) begin
      s = r ? src1_mem[8'(idx1 + k)] : src0_mem[8'(idx0 + k)];
      if (s == 8'd0 || s > 8'd6) exp_bad = 1'b1;
      exp_q.push_back(model_clamp(s));
    end
  endtask

  task automatic fill(input int r, input int len, input int lo, input int hi);
    for (int k = 0; k < len; k++) begin
      if (r == 1) src1_mem[8'(idx1 + k)] = 8'($urandom_range(hi, lo));
      else        src0_mem[8'(idx0 + k)] = 8'($urandom_range(hi, lo));
    end
  endtask

  // ---------------- frame observer ----------------
  logic [7:0] obs_syms[$];
  int   obs_grant, obs_grant_cyc, obs_clr, obs_clr_cyc, obs_first_sym_cyc;
  int   obs_tout_pulses, obs_tout_idx, obs_tout_cyc, obs_rv_cyc, obs_rv_lat;
  bit   obs_gap, obs_both, obs_timeout;
  logic [1:0] obs_err, obs_done, obs_grant_after;
  logic obs_id, obs_rv_after;
  bit   keep_req, disturb;

  function automatic int sym_diffs();
    int d = 0;
    if (obs_syms.size() != exp_q.size()) return 1000 + obs_syms.size();
    for (int k = 0; k < exp_q.size(); k++)
      if (obs_syms[k] !== exp_q[k]) d++;
    return d;
  endfunction

  task automatic run_frame(input int budget);
    int cv_cyc, last_sym_cyc;
    bit got, prev;
    obs_syms.delete();
    obs_grant = -1; obs_grant_cyc = -1; obs_clr = 0; obs_clr_cyc = -1; obs_first_sym_cyc = -1;
    obs_tout_pulses = 0; obs_tout_idx = -1; obs_tout_cyc = -1; obs_rv_cyc = -1; obs_rv_lat = -1;
    obs_gap = 0; obs_timeout = 0; obs_err = 2'bxx; obs_id = 1'bx;
    obs_done = 2'bxx; obs_grant_after = 2'bxx; obs_rv_after = 1'bx;
    cv_cyc = -1; last_sym_cyc = -1; got = 0; prev = 0;
    for (int cyc = 0; cyc < budget && !got; cyc++) begin
      @(negedge clk);
      res_ack_i = 1'b0;
      if (grant_o == 2'b11) obs_both = 1;
      if (obs_grant < 0 && grant_o != 2'b00) begin
        obs_grant = grant_o[1] ? 1 : 0;
        obs_grant_cyc = cyc;
      end
      if (core_rst_o) begin
        if (obs_syms.size() == 0) begin
          obs_clr++;
          obs_clr_cyc = cyc;
        end else begin
          obs_tout_pulses++;
          obs_tout_idx = cyc - last_sym_cyc - 1;
          obs_tout_cyc = cyc;
        end
      end
      if (gray_valid) begin
        if (obs_syms.size() != 0 && !prev) obs_gap = 1;
        if (obs_syms.size() == 0) obs_first_sym_cyc = cyc;
        obs_syms.push_back(gray_data);
        last_sym_cyc = cyc;
        if (disturb && obs_syms.size() == 1) begin
          req_i = 2'b00;
          res_ack_i = 1'b1;
        end
      end
      prev = gray_valid;
      if (code_valid && cv_cyc < 0) cv_cyc = cyc;
      if (res_valid) begin
        got = 1;
        obs_rv_cyc = cyc;
        obs_err = res_err;
        obs_id = res_id;
        if (cv_cyc >= 0) obs_rv_lat = cyc - cv_cyc;
      end
    end
    if (!got) begin
      obs_timeout = 1;
    end else begin
      res_ack_i = 1'b1;
      @(negedge clk);
      res_ack_i = 1'b0;
      obs_done = done_o;
      obs_grant_after = grant_o;
      obs_rv_after = res_valid;
      if (!keep_req) req_i = 2'b00;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_i = 2'b00; len0_i = '0; len1_i = '0; res_ack_i = 1'b0;
    core_hang = 0; core_delay = 3; keep_req = 0; disturb = 0; obs_both = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_o, grant_o, done_o, core_rst_o, gray_valid, gray_data, res_valid, res_id, res_err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rd_o, grant_o, done_o, core_rst_o, gray_valid, gray_data, res_valid, res_id, res_err});
    end
    reset = 1'b0;
    model_pref = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant_o, core_rst_o, gray_valid, res_valid} !== 5'd0) begin
      errors++;
      $display("FAIL idle_no_req got=%b exp=0", {grant_o, core_rst_o, gray_valid, res_valid});
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] pat [6];
    int g;
    pat = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
    for (int k = 0; k < 6; k++) src0_mem[8'(idx0 + k)] = pat[k];
    len0_i = 8'd6;
    g = model_pick(2'b01, model_pref); model_pref = 1 - g;
    model_frame(g, 6);
    core_delay = 3;
    req_i = 2'b01;
    run_frame(200);
    checks++;
    if (obs_timeout !== 0) begin errors++; $display("FAIL t1_result_seen got=timeout exp=res_valid"); end
    checks++;
    if (obs_clr !== 1 || obs_clr_cyc !== obs_grant_cyc || obs_first_sym_cyc !== obs_clr_cyc + 1) begin
      errors++;
      $display("FAIL t1_clr got=pulses%0d clr@%0d sym@%0d exp=1 pulse right before stream", obs_clr, obs_clr_cyc, obs_first_sym_cyc);
    end
    checks++;
    if (sym_diffs() != 0 || obs_gap !== 0) begin
      errors++;
      $display("FAIL t1_syms got diffs=%0d gap=%0d exp=0", sym_diffs(), obs_gap);
    end
    checks++;
    if (obs_rv_lat !== 1) begin errors++; $display("FAIL t1_rv_latency got=%0d exp=1", obs_rv_lat); end
    checks++;
    if ({obs_id, obs_err} !== 3'b000) begin errors++; $display("FAIL t1_id_err got=%b exp=000", {obs_id, obs_err}); end
    checks++;
    if ({obs_done, obs_grant_after, obs_rv_after} !== 5'b01000) begin
      errors++;
      $display("FAIL t1_ack got=%b exp=01000", {obs_done, obs_grant_after, obs_rv_after});
    end
  endtask

  task automatic test_random_frames();
    logic [1:0] pat;
    int l0, l1, g;
    for (int n = 0; n < 10; n++) begin
      pat = 2'($urandom_range(3, 1));
      l0 = $urandom_range(20, 1);
      l1 = $urandom_range(20, 1);
      fill(0, l0, 0, 8);
      fill(1, l1, 0, 8);
      len0_i = 8'(l0); len1_i = 8'(l1);
      g = model_pick(pat, model_pref); model_pref = 1 - g;
      model_frame(g, g ? l1 : l0);
      core_delay = $urandom_range(5, 1);
      req_i = pat;
      run_frame(300);
      checks++;
      if (obs_grant !== g || obs_id !== 1'(g)) begin
        errors++;
        $display("FAIL rnd%0d_grant got=%0d id=%0d exp=%0d", n, obs_grant, obs_id, g);
      end
      checks++;
      if (sym_diffs() != 0 || obs_err !== {1'b0, exp_bad} || obs_rv_lat !== 1) begin
        errors++;
        $display("FAIL rnd%0d_frame got diffs=%0d err=%b lat=%0d exp=0 %b 1", n, sym_diffs(), obs_err, obs_rv_lat, {1'b0, exp_bad});
      end
      checks++;
      if (obs_done !== (g ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rnd%0d_done got=%b exp=%b", n, obs_done, g ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_out_of_range();
    src1_mem[8'(idx1)] = 8'd0;
    src1_mem[8'(idx1 + 1)] = 8'd7;
    src1_mem[8'(idx1 + 2)] = 8'd4;
    len1_i = 8'd3;
    model_pref = 0;
    model_frame(1, 3);
    req_i = 2'b10;
    run_frame(200);
    checks++;
    if (obs_syms.size() != 3 || obs_syms[0] !== 8'd1 || obs_syms[1] !== 8'd6 || obs_syms[2] !== 8'd4) begin
      errors++;
      $display("FAIL t3_clamp got n=%0d first=%0d exp=1,6,4", obs_syms.size(), obs_syms.size() ? obs_syms[0] : 8'd0);
    end
    checks++;
    if ({obs_id, obs_err} !== 3'b101) begin errors++; $display("FAIL t3_err got=%b exp=101", {obs_id, obs_err}); end
  endtask

  task automatic test_ignored_inputs();
    int g;
    fill(0, 5, 1, 6);
    len0_i = 8'd5;
    g = model_pick(2'b01, model_pref); model_pref = 1 - g;
    model_frame(g, 5);
    disturb = 1;
    req_i = 2'b01;
    run_frame(200);
    disturb = 0;
    checks++;
    if (sym_diffs() != 0 || obs_gap !== 0 || obs_err !== 2'b00 || obs_done !== 2'b01) begin
      errors++;
      $display("FAIL drop_and_early_ack got diffs=%0d gap=%0d err=%b done=%b exp=0 0 00 01", sym_diffs(), obs_gap, obs_err, obs_done);
    end
  endtask

  task automatic test_timeout();
    int g;
    core_hang = 1;
    fill(0, 5, 1, 6);
    len0_i = 8'd5;
    g = model_pick(2'b01, model_pref); model_pref = 1 - g;
    req_i = 2'b01;
    run_frame(200);
    core_hang = 0;
    checks++;
    if (obs_tout_pulses !== 1 || obs_tout_idx !== TIMEOUT || obs_rv_cyc !== obs_tout_cyc + 1) begin
      errors++;
      $display("FAIL t4_pulse got=n%0d idx%0d rv@%0d exp=n1 idx%0d rv@%0d", obs_tout_pulses, obs_tout_idx, obs_rv_cyc, TIMEOUT, obs_tout_cyc + 1);
    end
    checks++;
    if (obs_err !== 2'b10 || obs_done !== 2'b01) begin
      errors++;
      $display("FAIL t4_err got=%b done=%b exp=10 01", obs_err, obs_done);
    end
    fill(1, 3, 1, 6);
    len1_i = 8'd3;
    g = model_pick(2'b10, model_pref); model_pref = 1 - g;
    model_frame(g, 3);
    req_i = 2'b10;
    run_frame(200);
    checks++;
    if (obs_grant !== 1 || sym_diffs() != 0 || obs_err !== 2'b00 || obs_tout_pulses !== 0 || obs_clr !== 1) begin
      errors++;
      $display("FAIL t4_next_frame got g=%0d diffs=%0d err=%b tp=%0d clr=%0d exp=1 0 00 0 1", obs_grant, sym_diffs(), obs_err, obs_tout_pulses, obs_clr);
    end
  endtask

  task automatic test_empty_frame();
    int g;
    len0_i = 8'd0;
    g = model_pick(2'b01, model_pref); model_pref = 1 - g;
    req_i = 2'b01;
    run_frame(50);
    checks++;
    if (obs_clr !== 0 || obs_syms.size() != 0 || obs_rv_cyc !== obs_grant_cyc) begin
      errors++;
      $display("FAIL t5_core_untouched got clr=%0d syms=%0d rv@%0d grant@%0d exp=0 0 same", obs_clr, obs_syms.size(), obs_rv_cyc, obs_grant_cyc);
    end
    checks++;
    if ({obs_id, obs_err, obs_done} !== 5'b01001) begin
      errors++;
      $display("FAIL t5_err got=%b exp=01001", {obs_id, obs_err, obs_done});
    end
  endtask

  task automatic test_back_to_back();
    int g;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_pref = 0;
    obs_both = 0;
    fill(0, 8, 1, 6);
    fill(1, 8, 0, 8);
    len0_i = 8'd4; len1_i = 8'd4;
    keep_req = 1;
    req_i = 2'b11;
    for (int n = 0; n < 4; n++) begin
      g = model_pick(2'b11, model_pref); model_pref = 1 - g;
      model_frame(g, 4);
      run_frame(200);
      checks++;
      if (obs_grant !== g || sym_diffs() != 0 || obs_err !== {1'b0, exp_bad}) begin
        errors++;
        $display("FAIL t2_frame%0d got g=%0d diffs=%0d err=%b exp g=%0d 0 %b", n, obs_grant, sym_diffs(), obs_err, g, {1'b0, exp_bad});
      end
    end
    keep_req = 0;
    req_i = 2'b00;
    checks++;
    if (obs_both !== 0) begin errors++; $display("FAIL t2_onehot got=both exp=onehot"); end
  endtask

  task automatic test_reset_mid_stream();
    int seen;
    bit reached;
    fill(0, 6, 1, 6);
    len0_i = 8'd6;
    req_i = 2'b01;
    seen = 0; reached = 0;
    for (int cyc = 0; cyc < 50 && !reached; cyc++) begin
      @(negedge clk);
      if (gray_valid) seen++;
      if (seen == 3) reached = 1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL t6_reach_sym3 got=%0d exp=3", seen); end
    reset = 1'b1;
    #1;
    checks++;
    if ({rd_o, grant_o, done_o, core_rst_o, gray_valid, gray_data, res_valid, res_id, res_err} !== 20'd0) begin
      errors++;
      $display("FAIL t6_reset_outputs got=%h exp=0",
               {rd_o, grant_o, done_o, core_rst_o, gray_valid, gray_data, res_valid, res_id, res_err});
    end
    @(negedge clk);
    fill(0, 2, 1, 6);
    len0_i = 8'd2;
    model_frame(0, 2);
    model_pref = 1;
    reset = 1'b0;
    run_frame(200);
    checks++;
    if (obs_grant !== 0 || obs_clr !== 1 || sym_diffs() != 0 || obs_err !== 2'b00) begin
      errors++;
      $display("FAIL t6_fresh_frame got g=%0d clr=%0d diffs=%0d err=%b exp=0 1 0 00", obs_grant, obs_clr, sym_diffs(), obs_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_out_of_range();
    test_ignored_inputs();
    test_timeout();
    test_empty_frame();
    test_back_to_back();
    test_reset_mid_stream();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
